// File: rtl/echo_corr_multi.sv
// echo_corr_multi: multi-hit +/-1-coded matched-filter echo correlator.
// Reads sample_count ADC samples from a non-showahead FIFO and correlates them
// against CODE. Each echo above corr_threshold is stored as (tof, peak) in a
// MAX_HITS-deep result bank.
// Optional feature macro ECHO_CORR_ABS_EN: when defined, mag = |corr|, so
// phase-inverted echoes are detected. Otherwise only positive correlation counts.
module echo_corr_multi #(
  parameter int              DATA_W    = 12,
  parameter int              TAPS      = 13,
  parameter logic [TAPS-1:0] CODE      = 13'b1111100110101,
  parameter int              DC_OFFSET = 2048,
  parameter int              CORR_W    = 18,
  parameter int              IDX_W     = 20,
  parameter int              MAX_HITS  = 4,
  parameter int              HC_W      = 3
) (
  input  logic              clk_50M,
  input  logic              rst_n,
  input  logic              sys_start_pulse,
  input  logic [IDX_W-1:0]  sample_count,
  input  logic [CORR_W-1:0] corr_threshold,
  input  logic [DATA_W-1:0] fifo_q,
  input  logic              fifo_empty,
  output logic              fifo_rdreq,
  input  logic [HC_W-1:0]   res_sel,
  output logic [IDX_W-1:0]  res_tof,
  output logic [CORR_W-1:0] res_peak,
  output logic [HC_W-1:0]   hit_count,
  output logic              hit_overflow,
  output logic [IDX_W-1:0]  echo_tof,
  output logic [CORR_W-1:0] echo_peak,
  output logic              hit_flag,
  output logic              busy,
  output logic              processing_done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  localparam logic signed [DATA_W:0] DC_S = (DATA_W+1)'(DC_OFFSET);

  state_t                  state;
  logic [IDX_W-1:0]        cnt_lat;
  logic [IDX_W-1:0]        req_cnt;
  logic                    finish;

  logic                    rd_v;
  logic signed [DATA_W:0]  centred;
  logic signed [DATA_W:0]  dl [TAPS];
  logic                    sh_v;
  logic [IDX_W-1:0]        sh_idx;
  logic [IDX_W-1:0]        samp_cnt;

  logic signed [CORR_W-1:0] corr_sum;
  logic signed [CORR_W-1:0] corr;
  logic                     corr_v;
  logic [IDX_W-1:0]         corr_idx;
  logic [CORR_W-1:0]        mag;

  logic                    ev_open, ev_open_n;
  logic [CORR_W-1:0]       ev_peak, ev_peak_n;
  logic [IDX_W-1:0]        ev_idx, ev_idx_n;
  logic                    commit;
  logic [CORR_W-1:0]       com_peak;
  logic [IDX_W-1:0]        com_idx;

  logic [IDX_W-1:0]        bank_tof  [MAX_HITS];
  logic [CORR_W-1:0]       bank_peak [MAX_HITS];

  assign fifo_rdreq = (state == S_RUN) && !fifo_empty && (req_cnt < cnt_lat);
  assign finish     = (state == S_DRAIN) && !rd_v && !sh_v;
  assign centred    = $signed({1'b0, fifo_q}) - DC_S;
  assign busy       = (state != S_IDLE);
  assign hit_flag   = (hit_count != '0);
  assign echo_tof   = bank_tof[0];
  assign echo_peak  = bank_peak[0];

  // Control FSM: a start always restarts; RUN issues reads; DRAIN waits for the pipeline, then pulses done
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      cnt_lat         <= '0;
      req_cnt         <= '0;
      processing_done <= 1'b0;
    end else begin
      processing_done <= 1'b0;
      if (sys_start_pulse) begin
        state   <= S_RUN;
        cnt_lat <= sample_count;
        req_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: state <= S_IDLE;
          S_RUN: begin
            if (fifo_rdreq) req_cnt <= req_cnt + IDX_W'(1);
            if (req_cnt == cnt_lat) state <= S_DRAIN;
          end
          S_DRAIN: begin
            if (finish) begin
              state           <= S_IDLE;
              processing_done <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Sum of the window with each tap signed by its template bit (bit 0 = newest sample)
  always_comb begin
    corr_sum = '0;
    for (int k = 0; k < TAPS; k++) begin
      if (CODE[k]) corr_sum = corr_sum + CORR_W'(dl[k]);
      else         corr_sum = corr_sum - CORR_W'(dl[k]);
    end
  end

  // Sample pipeline: capture returned FIFO data into the delay line, then register the correlation
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      rd_v     <= 1'b0;
      sh_v     <= 1'b0;
      sh_idx   <= '0;
      samp_cnt <= '0;
      corr_v   <= 1'b0;
      corr     <= '0;
      corr_idx <= '0;
      for (int k = 0; k < TAPS; k++) dl[k] <= '0;
    end else if (sys_start_pulse) begin
      rd_v     <= 1'b0;
      sh_v     <= 1'b0;
      sh_idx   <= '0;
      samp_cnt <= '0;
      corr_v   <= 1'b0;
      corr     <= '0;
      corr_idx <= '0;
      for (int k = 0; k < TAPS; k++) dl[k] <= '0;
    end else begin
      rd_v <= fifo_rdreq;
      sh_v <= rd_v;
      if (rd_v) begin
        dl[0] <= centred;
        for (int k = 1; k < TAPS; k++) dl[k] <= dl[k-1];
        sh_idx   <= samp_cnt;
        samp_cnt <= samp_cnt + IDX_W'(1);
      end
      corr_v <= sh_v && (sh_idx >= IDX_W'(TAPS-1));
      if (sh_v) begin
        corr     <= corr_sum;
        corr_idx <= sh_idx;
      end
    end
  end

  // Magnitude selection and next-state of the open event, including the forced commit at end of drain
  always_comb begin
`ifdef ECHO_CORR_ABS_EN
    mag = corr[CORR_W-1] ? $unsigned(-corr) : $unsigned(corr);
`else
    mag = (!corr[CORR_W-1] && (corr != '0)) ? $unsigned(corr) : '0;
`endif
    ev_open_n = ev_open;
    ev_peak_n = ev_peak;
    ev_idx_n  = ev_idx;
    commit    = 1'b0;
    com_peak  = ev_peak;
    com_idx   = ev_idx;
    if (corr_v) begin
      if (mag >= corr_threshold) begin
        if (!ev_open) begin
          ev_open_n = 1'b1;
          ev_peak_n = mag;
          ev_idx_n  = corr_idx;
        end else if (mag > ev_peak) begin
          ev_peak_n = mag;
          ev_idx_n  = corr_idx;
        end
      end else if (ev_open) begin
        commit    = 1'b1;
        ev_open_n = 1'b0;
      end
    end
    if (finish && ev_open_n) begin
      commit    = 1'b1;
      com_peak  = ev_peak_n;
      com_idx   = ev_idx_n;
      ev_open_n = 1'b0;
    end
  end

  // Event registers and result bank; a commit into a full bank only raises the sticky overflow
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      ev_open      <= 1'b0;
      ev_peak      <= '0;
      ev_idx       <= '0;
      hit_count    <= '0;
      hit_overflow <= 1'b0;
      for (int i = 0; i < MAX_HITS; i++) begin
        bank_tof[i]  <= '0;
        bank_peak[i] <= '0;
      end
    end else if (sys_start_pulse) begin
      ev_open      <= 1'b0;
      ev_peak      <= '0;
      ev_idx       <= '0;
      hit_count    <= '0;
      hit_overflow <= 1'b0;
      for (int i = 0; i < MAX_HITS; i++) begin
        bank_tof[i]  <= '0;
        bank_peak[i] <= '0;
      end
    end else begin
      ev_open <= ev_open_n;
      ev_peak <= ev_peak_n;
      ev_idx  <= ev_idx_n;
      if (commit) begin
        if (hit_count < HC_W'(MAX_HITS)) begin
          for (int i = 0; i < MAX_HITS; i++) begin
            if (HC_W'(i) == hit_count) begin
              bank_tof[i]  <= com_idx;
              bank_peak[i] <= com_peak;
            end
          end
          hit_count <= hit_count + HC_W'(1);
        end else begin
          hit_overflow <= 1'b1;
        end
      end
    end
  end

  // Result read port; unfilled slots read as zero
  always_comb begin
    res_tof  = '0;
    res_peak = '0;
    for (int i = 0; i < MAX_HITS; i++) begin
      if ((HC_W'(i) == res_sel) && (res_sel < hit_count)) begin
        res_tof  = bank_tof[i];
        res_peak = bank_peak[i];
      end
    end
  end

endmodule

// File: tb/tb_echo_corr_multi.sv
// tb_echo_corr_multi: self-checking bench for echo_corr_multi.
// A FIFO model feeds per-run sample arrays; expected hits come from a direct
// array-based correlation of the same samples.
module tb_echo_corr_multi;

  localparam int DATA_W   = 12;
  localparam int TAPS     = 13;
  localparam int CORR_W   = 18;
  localparam int IDX_W    = 20;
  localparam int MAX_HITS = 4;
  localparam int HC_W     = 3;
  localparam int DC       = 2048;

  logic              clk_50M = 1'b0;
  logic              rst_n = 1'b0;
  logic              sys_start_pulse = 1'b0;
  logic [IDX_W-1:0]  sample_count = '0;
  logic [CORR_W-1:0] corr_threshold = '0;
  logic [DATA_W-1:0] fifo_q = '0;
  logic              fifo_empty;
  logic              fifo_rdreq;
  logic [HC_W-1:0]   res_sel = '0;
  logic [IDX_W-1:0]  res_tof;
  logic [CORR_W-1:0] res_peak;
  logic [HC_W-1:0]   hit_count;
  logic              hit_overflow;
  logic [IDX_W-1:0]  echo_tof;
  logic [CORR_W-1:0] echo_peak;
  logic              hit_flag;
  logic              busy;
  logic              processing_done;

  logic [TAPS-1:0]   code_bits = 13'b1111100110101;

  int checks = 0;
  int errors = 0;

  int run_mem [0:1023];
  int run_len = 0;
  int pops = 0;
  int pops_base = 0;
  int stall_mode = 0;
  logic stall_phase = 1'b0;
  logic stall_rnd = 1'b0;

  int cyc = 0;
  int last_rd = -1;
  int done_at = -1;
  int done_cnt = 0;
  int rd_total = 0;
  int bad_rd = 0;

  int cur[$];
  int exp_tof[$];
  int exp_peak[$];
  bit exp_ovf;

  echo_corr_multi dut (
    .clk_50M(clk_50M), .rst_n(rst_n), .sys_start_pulse(sys_start_pulse),
    .sample_count(sample_count), .corr_threshold(corr_threshold),
    .fifo_q(fifo_q), .fifo_empty(fifo_empty), .fifo_rdreq(fifo_rdreq),
    .res_sel(res_sel), .res_tof(res_tof), .res_peak(res_peak),
    .hit_count(hit_count), .hit_overflow(hit_overflow),
    .echo_tof(echo_tof), .echo_peak(echo_peak), .hit_flag(hit_flag),
    .busy(busy), .processing_done(processing_done)
  );

  // 50 MHz clock
  always #10 clk_50M = ~clk_50M;

  assign fifo_empty = ((pops - pops_base) >= run_len) ||
                      (stall_mode == 1 && stall_phase) ||
                      (stall_mode == 2 && stall_rnd);

  // Non-showahead FIFO model: data appears the cycle after a read request
  always @(posedge clk_50M) begin
    stall_phase <= ~stall_phase;
    stall_rnd   <= ($urandom_range(0, 2) == 0);
    if (fifo_rdreq) begin
      fifo_q <= 12'(run_mem[(pops - pops_base) & 1023]);
      pops   <= pops + 1;
    end
  end

  // Cycle-stamped record of reads and done pulses
  always @(posedge clk_50M) begin
    cyc <= cyc + 1;
    if (fifo_rdreq) begin
      last_rd  <= cyc;
      rd_total <= rd_total + 1;
    end
    if (fifo_rdreq && fifo_empty) bad_rd <= bad_rd + 1;
    if (processing_done) begin
      done_cnt <= done_cnt + 1;
      done_at  <= cyc;
    end
  end

  // Global time limit so the run always ends
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic fill_flat(input int n);
    cur.delete();
    for (int i = 0; i < n; i++) cur.push_back(DC);
  endtask

  task automatic fill_noise(input int n, input int amp);
    cur.delete();
    for (int i = 0; i < n; i++) cur.push_back(DC + int'($urandom_range(0, 2 * amp)) - amp);
  endtask

  task automatic put_pattern(input int off, input int amp, input bit inv);
    for (int j = 0; j < TAPS; j++)
      cur[off + j] = (code_bits[TAPS-1-j] ^ inv) ? DC + amp : DC - amp;
  endtask

  task automatic model_commit(input int idx, input int pk);
    if (exp_tof.size() < MAX_HITS) begin
      exp_tof.push_back(idx);
      exp_peak.push_back(pk);
    end else begin
      exp_ovf = 1'b1;
    end
  endtask

  // Expected hits from a direct sliding-window correlation of cur[0..n-1]
  task automatic model_run(input int n, input int thr);
    int corr, mag, pk, pidx;
    bit open;
    exp_tof.delete();
    exp_peak.delete();
    exp_ovf = 1'b0;
    open = 1'b0;
    pk = 0;
    pidx = 0;
    for (int i = TAPS - 1; i < n; i++) begin
      corr = 0;
      for (int j = 0; j < TAPS; j++) begin
        if (code_bits[TAPS-1-j]) corr += cur[i-TAPS+1+j] - DC;
        else                     corr -= cur[i-TAPS+1+j] - DC;
      end
`ifdef ECHO_CORR_ABS_EN
      mag = (corr < 0) ? -corr : corr;
`else
      mag = (corr > 0) ? corr : 0;
`endif
      if (mag >= thr) begin
        if (!open) begin
          open = 1'b1; pk = mag; pidx = i;
        end else if (mag > pk) begin
          pk = mag; pidx = i;
        end
      end else if (open) begin
        model_commit(pidx, pk);
        open = 1'b0;
      end
    end
    if (open) model_commit(pidx, pk);
  endtask

  // Pulse start with the FIFO held empty, then expose the new run's samples
  task automatic start_run(input int n, input int thr, input int smode);
    @(negedge clk_50M);
    run_len = 0;
    stall_mode = smode;
    sample_count = IDX_W'(n);
    corr_threshold = CORR_W'(thr);
    sys_start_pulse = 1'b1;
    @(negedge clk_50M);
    sys_start_pulse = 1'b0;
    pops_base = pops;
    for (int i = 0; i < n; i++) run_mem[i] = cur[i];
    run_len = n;
  endtask

  task automatic wait_done(input int snap, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_50M);
      if (done_cnt != snap) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (6) @(negedge clk_50M);
  endtask

  task automatic test_reset();
    int rd_snap, dn_snap;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_50M);
    checks++;
    if ({fifo_rdreq, busy, processing_done, hit_flag, hit_overflow} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 00000",
               {fifo_rdreq, busy, processing_done, hit_flag, hit_overflow});
    end
    checks++;
    if (hit_count !== '0) begin
      errors++; $display("[TB] FAIL reset_hit_count: got %0d expected 0", hit_count);
    end
    checks++;
    if ({echo_tof, echo_peak} !== '0) begin
      errors++; $display("[TB] FAIL reset_echo: got tof %0d peak %0d expected 0", echo_tof, echo_peak);
    end
    checks++;
    if ({res_tof, res_peak} !== '0) begin
      errors++; $display("[TB] FAIL reset_res: got tof %0d peak %0d expected 0", res_tof, res_peak);
    end
    rst_n = 1'b1;
    rd_snap = rd_total;
    dn_snap = done_cnt;
    repeat (20) @(negedge clk_50M);
    checks++;
    if (rd_total != rd_snap) begin
      errors++; $display("[TB] FAIL idle_rdreq: got %0d reads expected 0", rd_total - rd_snap);
    end
    checks++;
    if (busy !== 1'b0 || done_cnt != dn_snap || hit_count !== '0) begin
      errors++;
      $display("[TB] FAIL idle_outputs: got busy %b dones %0d hits %0d expected 0 0 0",
               busy, done_cnt - dn_snap, hit_count);
    end
  endtask

  task automatic test_flat();
    int snap;
    bit ok;
    fill_flat(100);
    snap = done_cnt;
    start_run(100, 1, 0);
    wait_done(snap, 500, ok);
    checks++;
    if (!ok) begin
      errors++; $display("[TB] FAIL flat_done: got no done expected done pulse");
    end
    checks++;
    if (hit_count !== '0 || hit_flag !== 1'b0) begin
      errors++; $display("[TB] FAIL flat_hits: got count %0d flag %b expected 0 0", hit_count, hit_flag);
    end
    checks++;
    if (done_cnt - snap != 1) begin
      errors++; $display("[TB] FAIL flat_done_count: got %0d expected 1", done_cnt - snap);
    end
    checks++;
    if (done_at - last_rd != 4) begin
      errors++; $display("[TB] FAIL flat_latency: got %0d expected 4", done_at - last_rd);
    end
  endtask

  task automatic test_barker(input int smode);
    int snap;
    bit ok;
    fill_flat(100);
    put_pattern(50, 200, 1'b0);
    snap = done_cnt;
    start_run(100, 2000, smode);
    wait_done(snap, 800, ok);
    checks++;
    if (!ok || done_cnt - snap != 1) begin
      errors++; $display("[TB] FAIL barker_done(stall %0d): got %0d pulses expected 1", smode, done_cnt - snap);
    end
    checks++;
    if (hit_count !== 3'd1 || hit_flag !== 1'b1 || hit_overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL barker_count(stall %0d): got count %0d flag %b ovf %b expected 1 1 0",
               smode, hit_count, hit_flag, hit_overflow);
    end
    checks++;
    if (echo_tof !== 20'd62 || echo_peak !== 18'd2600) begin
      errors++;
      $display("[TB] FAIL barker_echo(stall %0d): got tof %0d peak %0d expected 62 2600",
               smode, echo_tof, echo_peak);
    end
    checks++;
    if (done_at - last_rd != 4) begin
      errors++; $display("[TB] FAIL barker_latency(stall %0d): got %0d expected 4", smode, done_at - last_rd);
    end
  endtask

  task automatic test_multi();
    int snap;
    bit ok;
    fill_flat(600);
    for (int k = 0; k < 5; k++) put_pattern(50 + 100 * k, 200, 1'b0);
    snap = done_cnt;
    start_run(600, 2000, 0);
    wait_done(snap, 1500, ok);
    checks++;
    if (!ok || hit_count !== 3'd4 || hit_overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL multi_count: got done %b count %0d ovf %b expected 1 4 1", ok, hit_count, hit_overflow);
    end
    for (int s = 0; s < MAX_HITS; s++) begin
      @(negedge clk_50M);
      res_sel = HC_W'(s);
      #1;
      checks++;
      if (res_tof !== IDX_W'(62 + 100 * s) || res_peak !== 18'd2600) begin
        errors++;
        $display("[TB] FAIL multi_slot%0d: got tof %0d peak %0d expected %0d 2600",
                 s, res_tof, res_peak, 62 + 100 * s);
      end
    end
    res_sel = 3'd5;
    #1;
    checks++;
    if ({res_tof, res_peak} !== '0) begin
      errors++; $display("[TB] FAIL multi_sel_oob: got tof %0d peak %0d expected 0 0", res_tof, res_peak);
    end
    res_sel = '0;
  endtask

  task automatic test_inverted();
    int snap;
    bit ok;
    fill_flat(100);
    put_pattern(50, 200, 1'b1);
    snap = done_cnt;
    start_run(100, 2000, 0);
    wait_done(snap, 500, ok);
    checks++;
`ifdef ECHO_CORR_ABS_EN
    if (!ok || hit_count !== 3'd1 || echo_tof !== 20'd62 || echo_peak !== 18'd2600) begin
      errors++;
      $display("[TB] FAIL inverted: got done %b count %0d tof %0d peak %0d expected 1 1 62 2600",
               ok, hit_count, echo_tof, echo_peak);
    end
`else
    if (!ok || hit_count !== 3'd0 || hit_flag !== 1'b0) begin
      errors++;
      $display("[TB] FAIL inverted: got done %b count %0d flag %b expected 1 0 0", ok, hit_count, hit_flag);
    end
`endif
  endtask

  task automatic test_restart();
    int snap;
    bit ok, seen30;
    fill_flat(100);
    put_pattern(10, 200, 1'b0);
    snap = done_cnt;
    start_run(100, 2000, 0);
    seen30 = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_50M);
      if (pops - pops_base >= 30) begin
        seen30 = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen30) begin
      errors++; $display("[TB] FAIL restart_progress: got %0d reads expected 30", pops - pops_base);
    end
    fill_flat(100);
    put_pattern(50, 200, 1'b0);
    start_run(100, 2000, 0);
    wait_done(snap, 500, ok);
    checks++;
    if (!ok || done_cnt - snap != 1) begin
      errors++; $display("[TB] FAIL restart_done_count: got %0d expected 1", done_cnt - snap);
    end
    checks++;
    if (hit_count !== 3'd1 || echo_tof !== 20'd62 || echo_peak !== 18'd2600 || hit_overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL restart_result: got count %0d tof %0d peak %0d ovf %b expected 1 62 2600 0",
               hit_count, echo_tof, echo_peak, hit_overflow);
    end
  endtask

  task automatic test_zero_count();
    int snap;
    bit ok;
    cur.delete();
    snap = done_cnt;
    start_run(0, 1, 0);
    wait_done(snap, 50, ok);
    checks++;
    if (!ok || done_cnt - snap != 1 || hit_count !== '0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_count: got dones %0d count %0d busy %b expected 1 0 0",
               done_cnt - snap, hit_count, busy);
    end
  endtask

  task automatic test_random();
    int n, thr, smode, snap, np, off;
    bit ok;
    int want_tof, want_peak;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(150, 400);
      fill_noise(n, $urandom_range(0, 60));
      np = $urandom_range(0, 6);
      for (int k = 0; k < np; k++) begin
        off = 20 + 55 * k + $urandom_range(0, 20);
        if (off + TAPS < n) put_pattern(off, $urandom_range(100, 300), $urandom_range(0, 1) == 1);
      end
      thr = $urandom_range(1200, 3000);
      smode = $urandom_range(0, 2);
      model_run(n, thr);
      snap = done_cnt;
      start_run(n, thr, smode);
      wait_done(snap, 4 * n + 100, ok);
      checks++;
      if (!ok || done_cnt - snap != 1) begin
        errors++; $display("[TB] FAIL rand%0d_done: got %0d pulses expected 1", r, done_cnt - snap);
      end
      checks++;
      if (hit_count !== HC_W'(exp_tof.size()) || hit_overflow !== exp_ovf) begin
        errors++;
        $display("[TB] FAIL rand%0d_count: got count %0d ovf %b expected %0d %b",
                 r, hit_count, hit_overflow, exp_tof.size(), exp_ovf);
      end
      checks++;
      if (done_at - last_rd != 4) begin
        errors++; $display("[TB] FAIL rand%0d_latency: got %0d expected 4", r, done_at - last_rd);
      end
      for (int s = 0; s < MAX_HITS; s++) begin
        @(negedge clk_50M);
        res_sel = HC_W'(s);
        #1;
        want_tof  = (s < exp_tof.size()) ? exp_tof[s] : 0;
        want_peak = (s < exp_tof.size()) ? exp_peak[s] : 0;
        checks++;
        if (res_tof !== IDX_W'(want_tof) || res_peak !== CORR_W'(want_peak)) begin
          errors++;
          $display("[TB] FAIL rand%0d_slot%0d: got tof %0d peak %0d expected %0d %0d",
                   r, s, res_tof, res_peak, want_tof, want_peak);
        end
      end
      res_sel = '0;
    end
  endtask

  task automatic test_reset_midrun();
    int snap;
    fill_flat(200);
    put_pattern(20, 200, 1'b0);
    snap = done_cnt;
    start_run(200, 2000, 0);
    repeat (60) @(negedge clk_50M);
    checks++;
    if (hit_count !== 3'd1 || busy !== 1'b1) begin
      errors++; $display("[TB] FAIL midrun_pre: got count %0d busy %b expected 1 1", hit_count, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || hit_count !== '0 || fifo_rdreq !== 1'b0 || echo_tof !== '0 || echo_peak !== '0) begin
      errors++;
      $display("[TB] FAIL midrun_reset: got busy %b count %0d rdreq %b tof %0d peak %0d expected all 0",
               busy, hit_count, fifo_rdreq, echo_tof, echo_peak);
    end
    repeat (3) @(negedge clk_50M);
    rst_n = 1'b1;
    repeat (20) @(negedge clk_50M);
    checks++;
    if (done_cnt != snap || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL midrun_after: got dones %0d busy %b expected 0 0", done_cnt - snap, busy);
    end
    run_len = 0;
  endtask

  task automatic test_protocol();
    checks++;
    if (bad_rd != 0) begin
      errors++; $display("[TB] FAIL rdreq_while_empty: got %0d expected 0", bad_rd);
    end
  endtask

  // Scenario sequence followed by the summary
  initial begin
    test_reset();
    test_flat();
    test_barker(0);
    test_barker(1);
    test_multi();
    test_inverted();
    test_restart();
    test_zero_count();
    test_random();
    test_reset_midrun();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
